// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux4_rr_arbiter                                              |
// | Description : Round-robin arbiter/sequencer for a shared 4:1 mux. Grants   |
// |               one of four requesters at a time with a bounded burst,       |
// |               drives the mux select and presents the routed data bit.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mux4_rr_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] i,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       valid,
    output logic       y,
    output logic       burst_end
);

    localparam logic       c_st_idle = 1'b0;
    localparam logic       c_st_busy = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(BURST_MAX - 1);

    logic             r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_gnt;
    logic [1:0]       r_s;
    logic             r_valid;
    logic             r_burst_end;

    logic             w_state_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_gnt_nxt;
    logic [1:0]       w_s_nxt;
    logic             w_valid_nxt;
    logic             w_burst_end_nxt;

    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic             w_found;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_release;

    assign w_cnt_inc = r_cnt + 1'b1;
    // Forced release at the burst limit wins regardless of the current request.
    assign w_release = !req[r_s] || (r_cnt == c_cnt_last);

    // Winner search: first active request scanning upward from the pointer.
    always_comb begin
        w_win   = r_ptr;
        w_idx   = r_ptr;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // Next-state and registered-output decode for the IDLE/BUSY sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_gnt_nxt       = r_gnt;
        w_s_nxt         = r_s;
        w_valid_nxt     = r_valid;
        w_burst_end_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (|req) begin
                    w_state_nxt     = c_st_busy;
                    w_gnt_nxt       = 4'b0001 << w_win;
                    w_s_nxt         = w_win;
                    w_valid_nxt     = 1'b1;
                    w_cnt_nxt       = '0;
                    w_burst_end_nxt = (c_cnt_last == '0);
                end
            end
            c_st_busy: begin
                if (w_release) begin
                    w_state_nxt = c_st_idle;
                    w_gnt_nxt   = 4'b0000;
                    w_valid_nxt = 1'b0;
                    w_ptr_nxt   = r_s + 2'd1;
                end else begin
                    w_cnt_nxt       = w_cnt_inc;
                    // Flag the upcoming cycle as the final one of a forced release.
                    w_burst_end_nxt = (w_cnt_inc == c_cnt_last);
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_ptr       <= 2'd0;
            r_cnt       <= '0;
            r_gnt       <= 4'b0000;
            r_s         <= 2'd0;
            r_valid     <= 1'b0;
            r_burst_end <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_s         <= w_s_nxt;
            r_valid     <= w_valid_nxt;
            r_burst_end <= w_burst_end_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign s         = r_s;
    assign valid     = r_valid;
    assign burst_end = r_burst_end;
    assign y         = r_valid & i[r_s];

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mux4_rr_arbiter                                           |
// | Description : Bench for mux4_rr_arbiter; two instances (burst limit 4 and  |
// |               1) share stimulus and are compared to a grant-level model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] i;

    logic [3:0] gnt0, gnt1;
    logic [1:0] s0, s1;
    logic       valid0, valid1, y0, y1, be0, be1;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: per instance, whether a grant is held, who holds it, how many
    // BUSY cycles it has lasted, where the next search starts.
    int m_busy [2];
    int m_own  [2];
    int m_len  [2];
    int m_ptr  [2];
    int m_sel  [2];
    int m_lim  [2] = '{4, 1};

    mux4_rr_arbiter #(.BURST_MAX(4), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .i(i),
        .gnt(gnt0), .s(s0), .valid(valid0), .y(y0), .burst_end(be0)
    );

    mux4_rr_arbiter #(.BURST_MAX(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .i(i),
        .gnt(gnt1), .s(s1), .valid(valid1), .y(y1), .burst_end(be1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_edge(input int m, input logic r, input logic [3:0] rq);
        if (r) begin
            m_busy[m] = 0; m_ptr[m] = 0; m_sel[m] = 0; m_len[m] = 0;
        end else if (m_busy[m] == 0) begin
            for (int j = 0; j < 4; j++) begin
                int k;
                k = (m_ptr[m] + j) % 4;
                if (m_busy[m] == 0 && rq[k]) begin
                    m_busy[m] = 1; m_own[m] = k; m_sel[m] = k; m_len[m] = 1;
                end
            end
        end else if (!rq[m_own[m]] || m_len[m] == m_lim[m]) begin
            m_busy[m] = 0;
            m_ptr[m]  = (m_own[m] + 1) % 4;
        end else begin
            m_len[m]++;
        end
    endtask

    task automatic compare(input int m, input logic [3:0] g, input logic [1:0] sv,
                           input logic v, input logic yv, input logic b);
        logic [3:0] eg;
        eg = (m_busy[m] != 0) ? 4'(1 << m_own[m]) : 4'b0000;
        chk($sformatf("d%0d_gnt", m), 32'(g), 32'(eg));
        chk($sformatf("d%0d_s", m), 32'(sv), 32'(m_sel[m]));
        chk($sformatf("d%0d_valid", m), 32'(v), 32'(m_busy[m] != 0));
        chk($sformatf("d%0d_y", m), 32'(yv), 32'((m_busy[m] != 0) && i[m_sel[m]]));
        chk($sformatf("d%0d_burst_end", m), 32'(b),
            32'((m_busy[m] != 0) && (m_len[m] == m_lim[m])));
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] d);
        rst = r; req = rq; i = d;
        @(posedge clk);
        model_edge(0, r, rq);
        model_edge(1, r, rq);
        #1;
        compare(0, gnt0, s0, valid0, y0, be0);
        compare(1, gnt1, s1, valid1, y1, be1);
    endtask

    initial begin
        logic [3:0] rq;
        for (int m = 0; m < 2; m++) begin
            m_busy[m] = 0; m_own[m] = 0; m_len[m] = 0; m_ptr[m] = 0; m_sel[m] = 0;
        end
        rst = 1'b1; req = 4'b0000; i = 4'b0000;

        // Reset held with every requester active.
        step(1'b1, 4'b1111, 4'b1010);
        step(1'b1, 4'b1111, 4'b1010);
        chk("rst_gnt", 32'(gnt0), 32'h0);
        chk("rst_valid", 32'(valid0), 32'h0);
        step(1'b0, 4'b1111, 4'b1010);
        chk("first_gnt", 32'(gnt0), 32'b0001);

        // Round robin with all requesting.
        for (int n = 0; n < 26; n++) step(1'b0, 4'b1111, 4'b0101);
        for (int n = 0; n < 3; n++)  step(1'b0, 4'b0000, 4'b0101);

        // Single requester, voluntary release after two cycles.
        step(1'b0, 4'b0100, 4'b0100);
        step(1'b0, 4'b0100, 4'b0100);
        chk("single_s", 32'(s0), 32'd2);
        for (int n = 0; n < 3; n++) step(1'b0, 4'b0000, 4'b0100);

        // Sole requester held: forced release, one idle cycle, re-grant.
        for (int n = 0; n < 12; n++) step(1'b0, 4'b0010, 4'b0010);

        // Wrap and skip pattern.
        for (int n = 0; n < 14; n++) step(1'b0, 4'b0101, 4'b1111);

        // Reset in the second BUSY cycle of a grant to requester 2.
        for (int n = 0; n < 3; n++) step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0100, 4'b0100);
        step(1'b0, 4'b0100, 4'b0100);
        step(1'b1, 4'b0100, 4'b0100);
        chk("midrst_valid", 32'(valid0), 32'h0);
        chk("midrst_be", 32'(be0), 32'h0);
        for (int n = 0; n < 6; n++) step(1'b0, 4'b1111, 4'b0011);

        // Randomised traffic with mostly-stable requests.
        rq = 4'b0000;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            step(($urandom_range(0, 59) == 0), rq, 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
